// File: rtl/dup_range_goal.sv
// dup_range_goal
// Walks the signed range base, base+step, ... while the value is < limit and
// emits every value twice on consecutive output beats, e.g. (0,10,2) gives
// 0,0,2,2,4,4,6,6,8,8. Uses the start/ready/valid/done generator handshake.
//
// Ports:
//   _clock  : system clock, all state changes on its rising edge
//   _reset  : asynchronous active-high reset
//   _start  : start request, samples base/limit/step (wins over everything)
//   _ready  : consumer ready, 0 freezes the generator completely
//   base    : signed first value of the range
//   limit   : signed exclusive upper bound
//   step    : signed increment (addition wraps modulo 2^WIDTH)
//   _done   : generator exhausted, held until the next start
//   _valid  : _0 carries an output beat this cycle
//   _0      : signed output value
module dup_range_goal #(
    parameter int WIDTH = 32
) (
    input  logic             _clock,
    input  logic             _reset,
    input  logic             _start,
    input  logic             _ready,
    input  logic [WIDTH-1:0] base,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] step,
    output logic             _done,
    output logic             _valid,
    output logic [WIDTH-1:0] _0
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] i_q, i_d;
    logic [WIDTH-1:0] lim_q, lim_d;
    logic [WIDTH-1:0] stp_q, stp_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             second_q, second_d;   // 1: next beat is the second copy of i
    logic             valid_q, valid_d;
    logic             done_q, done_d;

    // State register: every piece of state lives here so that a low _ready
    // holds all of it at once.
    always_ff @(posedge _clock or posedge _reset) begin
        if (_reset) begin
            state_q  <= IDLE;
            i_q      <= '0;
            lim_q    <= '0;
            stp_q    <= '0;
            out_q    <= '0;
            second_q <= 1'b0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            lim_q    <= lim_d;
            stp_q    <= stp_d;
            out_q    <= out_d;
            second_q <= second_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        lim_d    = lim_q;
        stp_d    = stp_q;
        out_d    = out_q;
        second_d = second_q;
        valid_d  = valid_q;
        done_d   = done_q;

        if (_start) begin
            // The first copy of base goes out on the start edge itself, so the
            // pending beat after it is the second copy.
            i_d    = base;
            lim_d  = limit;
            stp_d  = step;
            done_d = 1'b0;
            if ($signed(base) < $signed(limit)) begin
                out_d    = base;
                valid_d  = 1'b1;
                second_d = 1'b1;
                state_d  = RUN;
            end else begin
                valid_d  = 1'b0;
                second_d = 1'b0;
                done_d   = 1'b1;
                state_d  = DONE;
            end
        end else if (_ready) begin
            case (state_q)
                RUN: begin
                    if (second_q) begin
                        // Second copy: advance i only after it has been emitted.
                        out_d    = i_q;
                        valid_d  = 1'b1;
                        i_d      = i_q + stp_q;
                        second_d = 1'b0;
                    end else if ($signed(i_q) < $signed(lim_q)) begin
                        out_d    = i_q;
                        valid_d  = 1'b1;
                        second_d = 1'b1;
                    end else begin
                        // Out of range: _0 keeps the last value emitted.
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
                DONE: begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                end
                default: begin
                    valid_d = 1'b0;
                    done_d  = 1'b0;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        _0     = out_q;
        _valid = valid_q;
        _done  = done_q;
    end

endmodule

// File: tb/tb_dup_range_goal.sv
// Self-checking bench for dup_range_goal. Expected beats are pushed into a
// queue when a range is started and popped as the DUT presents accepted beats
// (valid while ready at the following edge).
module tb_dup_range_goal;

    logic        _clock = 1'b0;
    logic        _reset = 1'b1;
    logic        _start = 1'b0;
    logic        _ready = 1'b0;
    logic [31:0] base   = '0;
    logic [31:0] limit  = '0;
    logic [31:0] step   = '0;
    logic        _done;
    logic        _valid;
    logic [31:0] _0;

    int n_cmp = 0;
    int n_bad = 0;
    logic signed [31:0] exp_q[$];

    dup_range_goal #(.WIDTH(32)) dut (
        ._clock(_clock), ._reset(_reset), ._start(_start), ._ready(_ready),
        .base(base), .limit(limit), .step(step),
        ._done(_done), ._valid(_valid), ._0(_0)
    );

    always #5 _clock = ~_clock;

    // Expected beats of a terminating range: each value twice.
    task automatic push_range(input logic signed [31:0] b, input logic signed [31:0] l,
                              input logic signed [31:0] s);
        logic signed [31:0] v;
        v = b;
        while (v < l) begin
            exp_q.push_back(v);
            exp_q.push_back(v);
            v = v + s;
        end
    endtask

    // Called at a negedge; returns at the negedge after the start edge.
    task automatic start_gen(input logic signed [31:0] b, input logic signed [31:0] l,
                             input logic signed [31:0] s);
        _start = 1'b1;
        base   = b;
        limit  = l;
        step   = s;
        @(negedge _clock);
        _start = 1'b0;
        base   = 32'hDEAD_BEEF;
        limit  = 32'h1234_5678;
        step   = 32'hFFFF_0000;
    endtask

    task automatic test_reset();
        #3;
        n_cmp++;
        if (_valid !== 1'b0 || _done !== 1'b0 || _0 !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_async: valid=%b done=%b out=%0d, want 0/0/0", _valid, _done, _0);
        end
        @(negedge _clock);
        _reset = 1'b0;
        _ready = 1'b1;
        @(negedge _clock);
        @(negedge _clock);
        n_cmp++;
        if (_valid !== 1'b0 || _done !== 1'b0 || _0 !== 32'd0) begin
            n_bad++;
            $display("FAIL idle_no_start: valid=%b done=%b out=%0d, want 0/0/0", _valid, _done, _0);
        end
    endtask

    task automatic test_basic();
        int done_at;
        done_at = -1;
        @(negedge _clock);
        _ready = 1'b1;
        exp_q.delete();
        push_range(0, 10, 2);
        start_gen(0, 10, 2);
        for (int c = 0; c < 40; c++) begin
            if (_valid) begin
                n_cmp++;
                if (_done) begin
                    n_bad++;
                    $display("FAIL basic_done_with_valid: done=1 with valid beat at cycle %0d", c);
                end
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL basic_extra_beat: got %0d, want no beat", $signed(_0));
                end else begin
                    logic signed [31:0] e;
                    e = exp_q.pop_front();
                    if (_0 !== e) begin
                        n_bad++;
                        $display("FAIL basic_beat: got %0d, want %0d", $signed(_0), e);
                    end
                end
            end
            if (_done) begin
                done_at = c;
                break;
            end
            @(negedge _clock);
        end
        n_cmp++;
        if (done_at != 10) begin
            n_bad++;
            $display("FAIL basic_done_cycle: got %0d, want 10", done_at);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL basic_missing_beats: got %0d left, want 0", exp_q.size());
        end
        // Further ready cycles in DONE change nothing.
        repeat (3) @(negedge _clock);
        n_cmp++;
        if (_done !== 1'b1 || _valid !== 1'b0 || _0 !== 32'd8) begin
            n_bad++;
            $display("FAIL done_hold: done=%b valid=%b out=%0d, want 1/0/8", _done, _valid, _0);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge _clock);
        _ready = 1'b1;
        for (int r = 0; r < 5; r++) begin
            int done_at;
            done_at = -1;
            exp_q.delete();
            push_range(0, 10, 2);
            start_gen(0, 10, 2);
            n_cmp++;
            if (_done !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b_done_drop run %0d: done=%b, want 0", r, _done);
            end
            for (int c = 0; c < 40; c++) begin
                if (_valid) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL b2b_extra run %0d: got %0d, want no beat", r, $signed(_0));
                    end else begin
                        logic signed [31:0] e;
                        e = exp_q.pop_front();
                        if (_0 !== e) begin
                            n_bad++;
                            $display("FAIL b2b_beat run %0d: got %0d, want %0d", r, $signed(_0), e);
                        end
                    end
                end
                if (_done) begin
                    done_at = c;
                    break;
                end
                @(negedge _clock);
            end
            n_cmp++;
            if (done_at != 10 || exp_q.size() != 0) begin
                n_bad++;
                $display("FAIL b2b_end run %0d: done_at=%0d left=%0d, want 10/0", r, done_at, exp_q.size());
            end
            // Loop restarts right here: the next start hits the edge after _done.
        end
    endtask

    task automatic test_empty();
        logic signed [31:0] bl[2][2];
        bl[0][0] = 5; bl[0][1] = 5;
        bl[1][0] = 7; bl[1][1] = 3;
        @(negedge _clock);
        _ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            start_gen(bl[k][0], bl[k][1], 1);
            n_cmp++;
            if (_done !== 1'b1 || _valid !== 1'b0) begin
                n_bad++;
                $display("FAIL empty_%0d: done=%b valid=%b, want 1/0", k, _done, _valid);
            end
            @(negedge _clock);
            n_cmp++;
            if (_done !== 1'b1 || _valid !== 1'b0) begin
                n_bad++;
                $display("FAIL empty_hold_%0d: done=%b valid=%b, want 1/0", k, _done, _valid);
            end
        end
    endtask

    task automatic test_ready_toggle();
        logic        prev_r, prev_v, r;
        logic [31:0] prev_o;
        int          done_at;
        done_at = -1;
        @(negedge _clock);
        _ready = 1'b0;
        exp_q.delete();
        push_range(0, 10, 2);
        start_gen(0, 10, 2);
        prev_r = 1'b1;
        prev_v = 1'b0;
        prev_o = '0;
        for (int c = 0; c < 300; c++) begin
            if (!prev_r) begin
                n_cmp++;
                if (_0 !== prev_o || _valid !== prev_v) begin
                    n_bad++;
                    $display("FAIL toggle_stall: out=%0d valid=%b, want %0d/%b", $signed(_0), _valid, $signed(prev_o), prev_v);
                end
            end
            if (_done) begin
                done_at = c;
                break;
            end
            r = ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0;
            _ready = r;
            if (_valid && r) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL toggle_extra: got %0d, want no beat", $signed(_0));
                end else begin
                    logic signed [31:0] e;
                    e = exp_q.pop_front();
                    if (_0 !== e) begin
                        n_bad++;
                        $display("FAIL toggle_beat: got %0d, want %0d", $signed(_0), e);
                    end
                end
            end
            prev_r = r;
            prev_v = _valid;
            prev_o = _0;
            @(negedge _clock);
        end
        n_cmp++;
        if (done_at < 0 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL toggle_end: done_at=%0d left=%0d, want done/0", done_at, exp_q.size());
        end
        _ready = 1'b1;
    endtask

    task automatic test_steps();
        logic signed [31:0] t[2][3];
        t[0][0] = -3; t[0][1] = 4; t[0][2] = 3;
        t[1][0] = 1;  t[1][1] = 2; t[1][2] = 5;
        @(negedge _clock);
        _ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            int done_at;
            int nbeats;
            done_at = -1;
            exp_q.delete();
            push_range(t[k][0], t[k][1], t[k][2]);
            nbeats = exp_q.size();
            start_gen(t[k][0], t[k][1], t[k][2]);
            for (int c = 0; c < 40; c++) begin
                if (_valid) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL steps_extra_%0d: got %0d, want no beat", k, $signed(_0));
                    end else begin
                        logic signed [31:0] e;
                        e = exp_q.pop_front();
                        if (_0 !== e) begin
                            n_bad++;
                            $display("FAIL steps_beat_%0d: got %0d, want %0d", k, $signed(_0), e);
                        end
                    end
                end
                if (_done) begin
                    done_at = c;
                    break;
                end
                @(negedge _clock);
            end
            n_cmp++;
            if (done_at != nbeats || exp_q.size() != 0) begin
                n_bad++;
                $display("FAIL steps_end_%0d: done_at=%0d left=%0d, want %0d/0", k, done_at, exp_q.size(), nbeats);
            end
            @(negedge _clock);
        end
        // Wrap: 2147483644 + 4 wraps to the most negative value, still < limit.
        exp_q.delete();
        exp_q.push_back(32'sd2147483640);
        exp_q.push_back(32'sd2147483640);
        exp_q.push_back(32'sd2147483644);
        exp_q.push_back(32'sd2147483644);
        exp_q.push_back(-32'sd2147483648);
        exp_q.push_back(-32'sd2147483648);
        exp_q.push_back(-32'sd2147483644);
        start_gen(32'sd2147483640, 32'sd2147483647, 4);
        for (int c = 0; c < 7; c++) begin
            logic signed [31:0] e;
            e = exp_q.pop_front();
            n_cmp++;
            if (_valid !== 1'b1 || _done !== 1'b0 || _0 !== e) begin
                n_bad++;
                $display("FAIL wrap_beat %0d: valid=%b done=%b out=%0d, want 1/0/%0d", c, _valid, _done, $signed(_0), e);
            end
            @(negedge _clock);
        end
    endtask

    task automatic test_reset_mid_run();
        int done_at;
        @(negedge _clock);
        _ready = 1'b1;
        start_gen(0, 10, 2);
        @(negedge _clock);
        @(negedge _clock);
        n_cmp++;
        if (_valid !== 1'b1 || _0 !== 32'd2) begin
            n_bad++;
            $display("FAIL midrst_third_beat: valid=%b out=%0d, want 1/2", _valid, _0);
        end
        #2 _reset = 1'b1;
        #1;
        n_cmp++;
        if (_valid !== 1'b0 || _done !== 1'b0 || _0 !== 32'd0) begin
            n_bad++;
            $display("FAIL midrst_async: valid=%b done=%b out=%0d, want 0/0/0", _valid, _done, _0);
        end
        #1 _reset = 1'b0;
        @(negedge _clock);
        done_at = -1;
        exp_q.delete();
        push_range(0, 10, 2);
        start_gen(0, 10, 2);
        for (int c = 0; c < 40; c++) begin
            if (_valid) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL midrst_extra: got %0d, want no beat", $signed(_0));
                end else begin
                    logic signed [31:0] e;
                    e = exp_q.pop_front();
                    if (_0 !== e) begin
                        n_bad++;
                        $display("FAIL midrst_beat: got %0d, want %0d", $signed(_0), e);
                    end
                end
            end
            if (_done) begin
                done_at = c;
                break;
            end
            @(negedge _clock);
        end
        n_cmp++;
        if (done_at != 10 || exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL midrst_end: done_at=%0d left=%0d, want 10/0", done_at, exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_empty();
        test_ready_toggle();
        test_steps();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
